// File: rtl/ctrl_pipe_glacc_gen_pkg.sv
// Shared defaults for the global-accumulator control-delay pipeline.
`ifndef GCSP
`define GCSP 16
`endif

package ctrl_pipe_glacc_gen_pkg;
  localparam int RI_CH_DEF   = 0;
  localparam int THR_CH_DEF  = 1;
  localparam int DONE_CH_DEF = 2;
  localparam int MAXD_DEF    = 8;
  localparam int RST_DELAY   = 1;
  localparam int THRW_DEF    = `GCSP;

  function automatic int dw_of(input int maxd);
    return $clog2(maxd + 1);
  endfunction
endpackage

// File: rtl/ctrl_pipe_glacc_gen_ctrl_delay_line.sv
// One control channel: MAXD-stage strobe shift register with stall/flush and a
// runtime-selected output tap (tap 0 is the undelayed gated strobe).
module ctrl_delay_line
  import ctrl_pipe_glacc_gen_pkg::*;
#(
  parameter int MAXD = MAXD_DEF,
  parameter int DW   = dw_of(MAXD)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            g,
  input  logic            stall,
  input  logic            flush,
  input  logic [DW-1:0]   dly,
  output logic [MAXD:1]   stg,
  output logic            tap
);
  logic [MAXD:1] stg_q, stg_d;
  logic          sel;

  always_comb begin
    stg_d = stg_q;
    if (flush) begin
      stg_d = '0;
    end else if (!stall) begin
      stg_d[1] = g;
      for (int k = 2; k <= MAXD; k++) stg_d[k] = stg_q[k-1];
    end
  end

  always_comb begin
    sel = g;
    for (int k = 1; k <= MAXD; k++)
      if (dly == DW'(k)) sel = stg_q[k];
    // Blanking during stall keeps a held stage from re-emitting its strobe.
    tap = sel & ~stall & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stg_q <= '0;
    else        stg_q <= stg_d;
  end

  assign stg = stg_q;
endmodule

// File: rtl/ctrl_pipe_glacc_gen.sv
// Global-accumulator control-delay pipeline: NCH programmable strobe delays,
// token-advanced row-index / threshold lanes, compute_done, busy and cfg guard.
module ctrl_pipe_glacc_gen
  import ctrl_pipe_glacc_gen_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int MAXD    = MAXD_DEF,
  parameter int DW      = dw_of(MAXD),
  parameter int RIW     = 6,
  parameter int THRW    = THRW_DEF,
  parameter int RI_CH   = RI_CH_DEF,
  parameter int THR_CH  = THR_CH_DEF,
  parameter int DONE_CH = DONE_CH_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              cfg_load,
  input  logic [NCH*DW-1:0] cfg_delay,
  input  logic [NCH-1:0]    ch_gate,
  input  logic [NCH-1:0]    ctrl_in,
  input  logic [RIW-1:0]    row_index,
  input  logic [THRW-1:0]   et_thr,
  input  logic              stall,
  input  logic              flush,
  output logic [NCH-1:0]    ctrl_out,
  output logic [RIW-1:0]    ri_out,
  output logic [THRW-1:0]   thr_out,
  output logic              compute_done,
  output logic              busy,
  output logic              cfg_err
);
  logic [NCH-1:0]             g;
  logic [NCH-1:0][MAXD:1]     stg;
  logic [NCH-1:0][DW-1:0]     dly_q, dly_d;
  logic [MAXD:1][RIW-1:0]     ri_q, ri_d;
  logic [MAXD:1][THRW-1:0]    thr_q, thr_d;
  logic                       done_q, done_d;
  logic                       cfg_err_q, cfg_err_d;
  logic                       cfg_ok;

  assign g = ctrl_in & ch_gate;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ctrl_delay_line #(.MAXD(MAXD), .DW(DW)) u_dl (
      .clk   (CLK),
      .rst_n (RESET_N),
      .g     (g[i]),
      .stall (stall),
      .flush (flush),
      .dly   (dly_q[i]),
      .stg   (stg[i]),
      .tap   (ctrl_out[i])
    );
  end

  // Only stages up to the programmed tap can still produce an output.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NCH; i++)
      for (int k = 1; k <= MAXD; k++)
        if (DW'(k) <= dly_q[i]) busy = busy | stg[i][k];
  end

  always_comb begin
    cfg_ok    = cfg_load & ~busy & ~(|g);
    cfg_err_d = cfg_load & ~cfg_ok;
    dly_d     = dly_q;
    if (cfg_ok)
      for (int i = 0; i < NCH; i++)
        dly_d[i] = (cfg_delay[i*DW +: DW] > DW'(MAXD)) ? DW'(MAXD) : cfg_delay[i*DW +: DW];
    done_d = ctrl_out[DONE_CH];
  end

  // Data stages follow their channel's token; flush leaves them untouched.
  always_comb begin
    ri_d  = ri_q;
    thr_d = thr_q;
    if (!stall) begin
      if (g[RI_CH])  ri_d[1]  = row_index;
      if (g[THR_CH]) thr_d[1] = et_thr;
      for (int k = 2; k <= MAXD; k++) begin
        if (stg[RI_CH][k-1])  ri_d[k]  = ri_q[k-1];
        if (stg[THR_CH][k-1]) thr_d[k] = thr_q[k-1];
      end
    end
  end

  always_comb begin
    ri_out  = row_index;
    thr_out = et_thr;
    for (int k = 1; k <= MAXD; k++) begin
      if (dly_q[RI_CH]  == DW'(k)) ri_out  = ri_q[k];
      if (dly_q[THR_CH] == DW'(k)) thr_out = thr_q[k];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dly_q     <= {NCH{DW'(RST_DELAY)}};
      ri_q      <= '0;
      thr_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      dly_q     <= dly_d;
      ri_q      <= ri_d;
      thr_q     <= thr_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign compute_done = done_q;
  assign cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_ctrl_pipe_glacc_gen.sv
// Directed bench for ctrl_pipe_glacc_gen: delay/alignment, zero delay, stall,
// flush, cfg guard/saturation and reset mid-flight.
module tb_ctrl_pipe_glacc_gen;
  import ctrl_pipe_glacc_gen_pkg::*;
  localparam int NCH  = 8;
  localparam int MAXD = 8;
  localparam int DW   = dw_of(MAXD);
  localparam int RIW  = 6;
  localparam int THRW = THRW_DEF;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              cfg_load = 1'b0;
  logic [NCH*DW-1:0] cfg_delay = '0;
  logic [NCH-1:0]    ch_gate = '1;
  logic [NCH-1:0]    ctrl_in = '0;
  logic [RIW-1:0]    row_index = '0;
  logic [THRW-1:0]   et_thr = '0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [NCH-1:0]    ctrl_out;
  logic [RIW-1:0]    ri_out;
  logic [THRW-1:0]   thr_out;
  logic              compute_done, busy, cfg_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  ctrl_pipe_glacc_gen #(
    .NCH(NCH), .MAXD(MAXD), .DW(DW), .RIW(RIW), .THRW(THRW),
    .RI_CH(0), .THR_CH(1), .DONE_CH(2)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .cfg_load(cfg_load), .cfg_delay(cfg_delay),
    .ch_gate(ch_gate), .ctrl_in(ctrl_in), .row_index(row_index), .et_thr(et_thr),
    .stall(stall), .flush(flush), .ctrl_out(ctrl_out), .ri_out(ri_out),
    .thr_out(thr_out), .compute_done(compute_done), .busy(busy), .cfg_err(cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_ctrl_out", 32'(ctrl_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cfg_err", 32'(cfg_err), 32'h0);
    chk("rst_done", 32'(compute_done), 32'h0);
    chk("rst_ri", 32'(ri_out), 32'h0);
    chk("rst_thr", 32'(thr_out), 32'h0);
    nxt(); RESET_N = 1'b1;

    // program d0=4 d1=3 d2=4 d5=0, others 1
    nxt(); cfg_load = 1'b1; cfg_delay = 32'h1101_1434;
    nxt(); cfg_load = 1'b0; #1;
    chk("cfg_accept", 32'(cfg_err), 32'h0);

    // delay / alignment
    nxt(); ctrl_in = 8'h03; row_index = 6'h2A; et_thr = THRW'(16'h1234); #1;
    chk("t1_c0_out", 32'(ctrl_out), 32'h0);
    chk("t1_c0_busy", 32'(busy), 32'h0);
    nxt(); ctrl_in = 8'h00; row_index = 6'h15; et_thr = THRW'(16'h0BAD); #1;
    chk("t1_c1_busy", 32'(busy), 32'h1);
    chk("t1_c1_out", 32'(ctrl_out), 32'h0);
    nxt(); #1;
    chk("t1_c2_out", 32'(ctrl_out), 32'h0);
    nxt(); #1;
    chk("t1_c3_out", 32'(ctrl_out), 32'h02);
    chk("t1_c3_thr", 32'(thr_out), 32'h1234);
    nxt(); #1;
    chk("t1_c4_out", 32'(ctrl_out), 32'h01);
    chk("t1_c4_ri", 32'(ri_out), 32'h2A);
    nxt(); #1;
    chk("t1_c5_out", 32'(ctrl_out), 32'h0);
    chk("t1_c5_busy", 32'(busy), 32'h0);
    chk("t1_c5_ri_hold", 32'(ri_out), 32'h2A);
    chk("t1_c5_done", 32'(compute_done), 32'h0);

    // zero delay and gating
    nxt(); ctrl_in = 8'h20; #1;
    chk("t2_d0_out", 32'(ctrl_out), 32'h20);
    chk("t2_d0_busy", 32'(busy), 32'h0);
    nxt(); ch_gate = 8'hDF; #1;
    chk("t2_gate_out", 32'(ctrl_out), 32'h0);
    nxt(); ch_gate = 8'hFF; ctrl_in = 8'h00;

    // stall for cycles 2..4 on a d2=4 token
    nxt(); ctrl_in = 8'h04; #1;
    chk("t3_c0_out", 32'(ctrl_out), 32'h0);
    nxt(); ctrl_in = 8'h00;
    nxt(); stall = 1'b1; #1;
    chk("t3_c2_out", 32'(ctrl_out), 32'h0);
    chk("t3_c2_busy", 32'(busy), 32'h1);
    nxt(); ctrl_in = 8'h20; #1;
    chk("t3_stall_d0", 32'(ctrl_out), 32'h0);
    nxt(); ctrl_in = 8'h00;
    nxt(); stall = 1'b0; #1;
    chk("t3_c5_out", 32'(ctrl_out), 32'h0);
    nxt(); #1;
    chk("t3_c6_out", 32'(ctrl_out), 32'h0);
    nxt(); #1;
    chk("t3_c7_out", 32'(ctrl_out), 32'h04);
    chk("t3_c7_done", 32'(compute_done), 32'h0);
    nxt(); #1;
    chk("t3_c8_out", 32'(ctrl_out), 32'h0);
    chk("t3_c8_done", 32'(compute_done), 32'h1);
    nxt(); #1;
    chk("t3_c9_done", 32'(compute_done), 32'h0);

    // flush two in-flight tokens
    nxt(); ctrl_in = 8'h04;
    nxt(); ctrl_in = 8'h04;
    nxt(); ctrl_in = 8'h00; flush = 1'b1; #1;
    chk("t4_flush_out", 32'(ctrl_out), 32'h0);
    chk("t4_preflush_busy", 32'(busy), 32'h1);
    nxt(); flush = 1'b0; #1;
    chk("t4_post_busy", 32'(busy), 32'h0);
    for (int n = 0; n < 6; n++) begin
      chk("t4_quiet_out", 32'(ctrl_out), 32'h0);
      chk("t4_quiet_done", 32'(compute_done), 32'h0);
      nxt(); #1;
    end
    chk("t4_ri_kept", 32'(ri_out), 32'h2A);
    chk("t4_thr_kept", 32'(thr_out), 32'h1234);

    // cfg guard: reject while busy, reject with a live strobe, then saturate
    nxt(); ctrl_in = 8'h01;
    nxt(); ctrl_in = 8'h00; cfg_load = 1'b1; cfg_delay = 32'h2222_2222; #1;
    chk("t5_busy", 32'(busy), 32'h1);
    nxt(); cfg_load = 1'b0; #1;
    chk("t5_err_pulse", 32'(cfg_err), 32'h1);
    nxt(); #1;
    chk("t5_err_clear", 32'(cfg_err), 32'h0);
    nxt(); #1;
    chk("t5_dly_kept", 32'(ctrl_out), 32'h01);
    nxt(); cfg_load = 1'b1; cfg_delay = 32'h1101_143F; ctrl_in = 8'h08; #1;
    chk("t5_idle_busy", 32'(busy), 32'h0);
    nxt(); cfg_load = 1'b0; ctrl_in = 8'h00; #1;
    chk("t5_g_reject", 32'(cfg_err), 32'h1);
    chk("t5_d3_out", 32'(ctrl_out), 32'h08);
    nxt(); cfg_load = 1'b1; #1;
    chk("t5_busy_0", 32'(busy), 32'h0);
    nxt(); cfg_load = 1'b0; #1;
    chk("t5_sat_accept", 32'(cfg_err), 32'h0);
    nxt(); ctrl_in = 8'h01;
    nxt(); ctrl_in = 8'h00;
    repeat (6) nxt();
    #1;
    chk("t5_sat_d7", 32'(ctrl_out), 32'h0);
    nxt(); #1;
    chk("t5_sat_d8", 32'(ctrl_out), 32'h01);

    // reset with three tokens in flight
    nxt(); ctrl_in = 8'h04;
    nxt(); ctrl_in = 8'h05;
    nxt(); ctrl_in = 8'h00; #1;
    chk("t6_busy", 32'(busy), 32'h1);
    #1; RESET_N = 1'b0; #1;
    chk("t6_rst_out", 32'(ctrl_out), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_done", 32'(compute_done), 32'h0);
    chk("t6_rst_err", 32'(cfg_err), 32'h0);
    chk("t6_rst_ri", 32'(ri_out), 32'h0);
    chk("t6_rst_thr", 32'(thr_out), 32'h0);
    nxt(); RESET_N = 1'b1;
    for (int n = 0; n < 12; n++) begin
      nxt(); #1;
      chk("t6_no_stale_out", 32'(ctrl_out), 32'h0);
      chk("t6_no_stale_done", 32'(compute_done), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe_glacc_gen.md
Name: ctrl_pipe_glacc_gen

Overview:
- Parametrised control-delay pipeline for the global accumulator.
- Carries NCH single-bit control strobes, each through its own runtime-programmable delay of 0..MAXD cycles.
- Carries two data lanes (row index, early-termination threshold). Each lane advances only with its update token.
- Generates a registered compute_done pulse. Adds stall, flush and busy behaviour; replaces fixed-depth per-signal delay chains.

Parameters:
- NCH, 8, number of 1-bit control channels
- MAXD, 8, maximum per-channel delay in cycles (>=1)
- DW, $clog2(MAXD+1), width of one delay field
- RIW, 6, row-index width
- THRW, `GCSP, threshold width
- RI_CH, 0, channel whose strobe is the row-index update token
- THR_CH, 1, channel whose strobe is the threshold update token
- DONE_CH, 2, channel whose delayed strobe produces compute_done

Ports:
- CLK  in  1  clock
- RESET_N  in  1  asynchronous active-low reset
- cfg_load  in  1  load cfg_delay into delay registers
- cfg_delay  in  NCH*DW  per-channel delay; field i = bits [i*DW +: DW]
- ch_gate  in  NCH  per-channel enable; ctrl_in[i] is ANDed with ch_gate[i] before entry
- ctrl_in  in  NCH  raw control strobes
- row_index  in  RIW  row index, sampled with the RI_CH token
- et_thr  in  THRW  threshold, sampled with the THR_CH token
- stall  in  1  freeze the pipeline
- flush  in  1  clear the pipeline
- ctrl_out  out  NCH  delayed strobes
- ri_out  out  RIW  row index aligned to ctrl_out[RI_CH]
- thr_out  out  THRW  threshold aligned to ctrl_out[THR_CH]
- compute_done  out  1  one-cycle pulse, one cycle after ctrl_out[DONE_CH]
- busy  out  1  any token in flight
- cfg_err  out  1  one-cycle pulse when cfg_load is rejected

Behaviour:
- Reset (asynchronous):
  - all stage registers, ctrl_out, ri_out, thr_out, compute_done, busy and cfg_err go to 0.
  - every channel delay goes to 1.
- Structure:
  - each channel i is a MAXD-stage shift register s_i[1..MAXD]; stage 1 samples g_i = ctrl_in[i] & ch_gate[i].
  - delay d_i = 0: ctrl_out[i] = g_i combinationally (zero latency; stall does not apply, see Stall).
  - delay d_i >= 1: ctrl_out[i] = s_i[d_i], i.e. exactly d_i cycles of latency.
- Data lanes:
  - RI lane: stage k holds a RIW value; it captures from stage k-1 (stage 1 from row_index) only on a cycle where s_RI_CH[k-1] (stage 1: g_RI_CH) is 1 and there is no stall. Otherwise it holds.
  - ri_out = RI-lane stage d_RI_CH, or row_index when d_RI_CH = 0. It holds its last value between tokens.
  - THR lane: identical rule using the THR_CH token and et_thr.
  - Flush does not clear either data lane.
- Stall:
  - on a stall=1 edge, all control stages and data stages hold.
  - while stall is high, ctrl_out is forced to 0 on every channel, including d_i = 0 channels. This prevents duplicate strobes.
  - a strobe presented on ctrl_in during stall is dropped.
- Flush:
  - on a flush=1 edge, all control stages are cleared.
  - flush overrides stall; ctrl_out is 0 in the flush cycle.
- compute_done:
  - a register sampling ctrl_out[DONE_CH]; one pulse per token.
  - back-to-back tokens give back-to-back pulses.
- busy = OR of all control stages at indices 1..d_i across all channels (registered stage contents only).
- Configuration:
  - cfg_load accepted only when busy = 0 and no g_i is asserted that cycle. New delays take effect from the next cycle.
  - otherwise the load is ignored and cfg_err pulses for 1 cycle.
  - a field value greater than MAXD saturates to MAXD.
- Simultaneous events:
  - flush and cfg_load in the same cycle: flush executes, and the load is evaluated against pre-flush busy.
  - tokens entering in the same cycle as flush are also dropped.
- Reset mid-operation: all in-flight tokens are lost; no compute_done is generated for them.

Decomposition:
- Shared package:
  - default channel indices (RI_CH, THR_CH, DONE_CH)
  - MAXD default
  - DW derivation function
  - a localparam for the default reset delay of 1
- One sub-module, ctrl_delay_line: one channel's MAXD-stage shift register with stall/flush and a tap mux.
  - NCH instances via a generate loop.
  - data lanes are written inline.
- The existing rb register cell stays unchanged and may be reused for data stages.

Test Plan:
- Delay/alignment: after reset, cfg_delay = {2:4, 1:3, 0:4}, one token on ctrl_in[0] with row_index = 6'h2A, ch_gate all 1 → ctrl_out[0] high exactly 4 cycles later with ri_out = 6'h2A; compute_done silent.
- Zero delay and gating: d_5 = 0 → ctrl_out[5] follows ctrl_in[5] in the same cycle. ch_gate[5] = 0 → ctrl_out[5] stays 0.
- Stall: token on ctrl_in[2] with d_2 = 4, stall asserted for 3 cycles at cycle 2 → ctrl_out[2] at cycle 7. compute_done at cycle 8, exactly once.
- Flush: two tokens in flight on channel 2, flush for one cycle → no ctrl_out[2], no compute_done, busy = 0 on the next cycle; ri_out and thr_out unchanged.
- Config guard: cfg_load while busy = 1 → cfg_err pulse and delays unchanged. cfg_load with busy = 0 and field = 15 (MAXD = 8) → delay 8.
- Reset mid-flight: RESET_N low with 3 tokens in flight → all outputs 0 immediately; after release, no stale ctrl_out or compute_done pulses.
